// File: rtl/event_stream_arbiter.sv
// Round-robin event source arbiter with burst hold and one output register.
// Optional EVENT_ARB_POL_DROP_EN: consume p=0 events without forwarding.
module event_stream_arbiter #(
  parameter int N_SRC     = 4,
  parameter int BURST_LEN = 1,
  parameter int SW        = $clog2(N_SRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     in_valid,
  output logic [N_SRC-1:0]     in_ready,
  input  logic [16*N_SRC-1:0]  in_x,
  input  logic [16*N_SRC-1:0]  in_y,
  input  logic [16*N_SRC-1:0]  in_t,
  input  logic [N_SRC-1:0]     in_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_x,
  output logic [15:0]          out_y,
  output logic [15:0]          out_t,
  output logic                 out_p,
  output logic [SW-1:0]        out_src,
  output logic [15:0]          evt_count
`ifdef EVENT_ARB_POL_DROP_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]    state;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] owner;
  logic [3:0]    burst_cnt;

  logic          load_en;
  logic          own_hit;
  logic          scan_hit;
  logic [SW-1:0] base;
  logic [SW-1:0] scan_g;
  logic [SW-1:0] g;
  logic          xfer;
  logic          drop;

  function automatic logic [SW-1:0] add_wrap(
    input logic [SW-1:0] b,
    input int            j
  );
    int s;
    s = int'(b) + j;
    if (s >= N_SRC) s = s - N_SRC;
    return SW'(s);
  endfunction

  assign load_en = !out_valid || out_ready;

  // A burst owner that went idle hands over to owner+1 in the same cycle.
  always_comb begin
    base     = rr_ptr;
    own_hit  = 1'b0;
    scan_hit = 1'b0;
    scan_g   = rr_ptr;
    if (state == BURST) begin
      if (in_valid[owner]) own_hit = 1'b1;
      else base = add_wrap(owner, 1);
    end
    for (int j = N_SRC - 1; j >= 0; j--) begin
      if (in_valid[add_wrap(base, j)]) begin
        scan_hit = 1'b1;
        scan_g   = add_wrap(base, j);
      end
    end
  end

  assign g    = own_hit ? owner : scan_g;
  assign xfer = load_en && (own_hit || scan_hit);

`ifdef EVENT_ARB_POL_DROP_EN
  assign drop = xfer && !in_p[g];
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_t     <= '0;
      out_p     <= 1'b0;
      out_src   <= '0;
      evt_count <= '0;
    end else begin
      if (out_valid && out_ready && evt_count != 16'hFFFF)
        evt_count <= evt_count + 16'd1;
      if (load_en) begin
        out_valid <= xfer && !drop;
        if (xfer && !drop) begin
          out_x   <= in_x[16*g +: 16];
          out_y   <= in_y[16*g +: 16];
          out_t   <= in_t[16*g +: 16];
          out_p   <= in_p[g];
          out_src <= g;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else if (load_en) begin
      if (state == BURST && !own_hit) begin
        state     <= IDLE;
        rr_ptr    <= add_wrap(owner, 1);
        burst_cnt <= '0;
      end
      if (xfer) begin
        if (own_hit) begin
          if (burst_cnt + 4'd1 == 4'(BURST_LEN)) begin
            state     <= IDLE;
            rr_ptr    <= add_wrap(owner, 1);
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end else if (BURST_LEN == 1) begin
          state  <= IDLE;
          rr_ptr <= add_wrap(g, 1);
        end else begin
          state     <= BURST;
          owner     <= g;
          burst_cnt <= 4'd1;
        end
      end
    end
  end

`ifdef EVENT_ARB_POL_DROP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_event_stream_arbiter.sv
// Bench for event_stream_arbiter: two instances (burst 1 and 3), random
// stimulus, grant-streak reference model and per-instance scoreboards.
module tb_event_stream_arbiter;

  localparam int N = 4;
  localparam int SW = 2;
`ifdef EVENT_ARB_POL_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef logic [50:0] ev_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [16*N-1:0] in_x = '0;
  logic [16*N-1:0] in_y = '0;
  logic [16*N-1:0] in_t = '0;
  logic [N-1:0]    in_p = '0;
  logic            out_ready = 1'b0;

  logic [N-1:0]  rdy [2];
  logic          ov  [2];
  logic [15:0]   ox  [2];
  logic [15:0]   oy  [2];
  logic [15:0]   ot  [2];
  logic          op  [2];
  logic [SW-1:0] osrc[2];
  logic [15:0]   ecnt[2];
  logic [15:0]   dcnt[2];

  int errs = 0;
  int checks = 0;

  ev_t sbq [2][$];

  int m_last [2];
  int m_run  [2];
  int m_cnt  [2];
  int m_dcnt [2];
  bit m_valid[2];
  int p_g    [2];
  bit p_cont [2];
  bit p_load [2];

  always #5 clk = ~clk;

`ifndef EVENT_ARB_POL_DROP_EN
  assign dcnt[0] = '0;
  assign dcnt[1] = '0;
`endif

  event_stream_arbiter #(.N_SRC(N), .BURST_LEN(1)) u_b1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .in_x(in_x), .in_y(in_y), .in_t(in_t), .in_p(in_p),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_x(ox[0]), .out_y(oy[0]), .out_t(ot[0]),
    .out_p(op[0]), .out_src(osrc[0]),
    .evt_count(ecnt[0])
`ifdef EVENT_ARB_POL_DROP_EN
    , .drop_count(dcnt[0])
`endif
  );

  event_stream_arbiter #(.N_SRC(N), .BURST_LEN(3)) u_b3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .in_x(in_x), .in_y(in_y), .in_t(in_t), .in_p(in_p),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_x(ox[1]), .out_y(oy[1]), .out_t(ot[1]),
    .out_p(op[1]), .out_src(osrc[1]),
    .evt_count(ecnt[1])
`ifdef EVENT_ARB_POL_DROP_EN
    , .drop_count(dcnt[1])
`endif
  );

  function automatic int blen(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k]  = N - 1;
      m_run[k]   = blen(k);
      m_cnt[k]   = 0;
      m_dcnt[k]  = 0;
      m_valid[k] = 1'b0;
      sbq[k].delete();
    end
  endtask

  task automatic reset_chk(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), 64'(ov[k]), 0);
      chk($sformatf("%s_x%0d", tag, k), 64'(ox[k]), 0);
      chk($sformatf("%s_y%0d", tag, k), 64'(oy[k]), 0);
      chk($sformatf("%s_t%0d", tag, k), 64'(ot[k]), 0);
      chk($sformatf("%s_p%0d", tag, k), 64'(op[k]), 0);
      chk($sformatf("%s_src%0d", tag, k), 64'(osrc[k]), 0);
      chk($sformatf("%s_cnt%0d", tag, k), 64'(ecnt[k]), 0);
      if (DROP)
        chk($sformatf("%s_dcnt%0d", tag, k), 64'(dcnt[k]), 0);
    end
  endtask

  // Model: continue the current streak while it is short enough and its
  // source is still valid; otherwise the first valid source after the
  // last granted one wins and starts a new streak.
  task automatic step(input logic [N-1:0] v, input logic ordy,
                      input bit pz, input logic [15:0] fx);
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      in_x[16*i +: 16] = (fx != 0) ? fx : 16'($urandom);
      in_y[16*i +: 16] = 16'($urandom);
      in_t[16*i +: 16] = 16'($urandom);
      in_p[i] = pz ? 1'b0 : 1'($urandom);
    end
    for (int k = 0; k < 2; k++) begin
      p_load[k] = !m_valid[k] || ordy;
      p_g[k]    = -1;
      p_cont[k] = 1'b0;
      if (p_load[k]) begin
        if (m_run[k] < blen(k) && v[m_last[k]]) begin
          p_g[k]    = m_last[k];
          p_cont[k] = 1'b1;
        end else begin
          for (int j = N; j >= 1; j--)
            if (v[(m_last[k] + j) % N]) p_g[k] = (m_last[k] + j) % N;
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_rdy = '0;
      if (p_g[k] >= 0) exp_rdy[p_g[k]] = 1'b1;
      chk($sformatf("in_ready%0d", k), 64'(rdy[k]), 64'(exp_rdy));
      chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(m_valid[k]));
      chk($sformatf("evt_count%0d", k), 64'(ecnt[k]), 64'(m_cnt[k]));
      if (DROP)
        chk($sformatf("drop_count%0d", k), 64'(dcnt[k]), 64'(m_dcnt[k]));
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      int gg;
      bit dr;
      gg = p_g[k];
      if (m_valid[k] && ordy && m_cnt[k] < 65535) m_cnt[k]++;
      if (p_load[k]) begin
        if (gg >= 0) begin
          dr = DROP && !in_p[gg];
          if (p_cont[k]) m_run[k]++;
          else begin
            m_last[k] = gg;
            m_run[k]  = 1;
          end
          if (dr) begin
            if (m_dcnt[k] < 65535) m_dcnt[k]++;
          end else begin
            sbq[k].push_back({2'(gg), in_x[16*gg +: 16],
                              in_y[16*gg +: 16], in_t[16*gg +: 16],
                              in_p[gg]});
          end
          m_valid[k] = !dr;
        end else begin
          m_valid[k] = 1'b0;
          m_run[k]   = blen(k);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (ov[k]) begin
          if (sbq[k].size() == 0) begin
            chk($sformatf("sb_nonempty%0d", k), 0, 1);
          end else begin
            chk($sformatf("event%0d", k),
                64'({osrc[k], ox[k], oy[k], ot[k], op[k]}),
                64'(sbq[k][0]));
            if (out_ready) void'(sbq[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset_chk("rst0");
    rst = 1'b0;

    repeat (10) step(4'hF, 1'b1, 1'b0, 16'h0);
    repeat (3) step(4'h0, 1'b1, 1'b0, 16'h0);
    repeat (8) step(4'b0101, 1'b1, 1'b0, 16'h0);

    step(4'h1, 1'b1, 1'b0, 16'h1234);
    repeat (5) step(4'hF, 1'b0, 1'b0, 16'h0);
    step(4'hF, 1'b1, 1'b0, 16'h0);

    repeat (3) step(4'h0, 1'b1, 1'b0, 16'h0);
    step(4'b0010, 1'b1, 1'b0, 16'h0);
    step(4'b0100, 1'b1, 1'b0, 16'h0);
    step(4'b0100, 1'b1, 1'b0, 16'h0);

    repeat (3000)
      step(4'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 16'h0);

    step(4'hF, 1'b1, 1'b0, 16'h0);
    step(4'hF, 1'b0, 1'b0, 16'h0);
    chk("pre_rst_valid", 64'(ov[0]), 1);
    #2 rst = 1'b1;
    #1 reset_chk("rst1");
    model_reset();
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    step(4'h1, 1'b1, 1'b1, 16'h0);
    step(4'h0, 1'b1, 1'b0, 16'h0);
    step(4'h0, 1'b1, 1'b0, 16'h0);

    repeat (4) step(4'h0, 1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 2; k++)
      chk($sformatf("sb_drained%0d", k), 64'(sbq[k].size()), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
